lzw_code_packer: RTL and testbench

Downstream stage of the LZW dictionary/register datapath. It consumes the 12-bit codes emitted on that datapath's code output and packs them MSB-first into a continuous bitstream of 16-bit words. The words pass through a small output FIFO towards the output RAM/UART writer. An end-of-stream flush pads the final partial word with zeros and signals completion.

---
 rtl/lzw_code_packer.sv | 210 +++++++++++++++++++++
 tb/tb_lzw_code_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_code_packer.sv
// lzw_code_packer
//   Packs fixed-width LZW codes MSB-first into a continuous stream of
//   WORD_W-bit words. The words are queued in a small FIFO for the output
//   writer. An end-of-stream flush zero-pads the last partial word, waits
//   for the FIFO to drain and then pulses oFlushDone.
//
// Ports
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   iCode        code from the dictionary datapath
//   iCodeValid   iCode valid this cycle
//   oCodeReady   packer accepts iCode this cycle (independent of iCodeValid)
//   iFlush       one-cycle end-of-stream request
//   oFlushDone   one-cycle pulse: all bits emitted and FIFO drained
//   oWord        FIFO head word
//   oWordValid   FIFO not empty
//   iWordReady   consumer pops oWord when high together with oWordValid
//   oWordCount   total words popped, wraps
//   oBusy        flush in progress, bits pending or words queued
module lzw_code_packer #(
  parameter int CODE_W     = 12,
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [CODE_W-1:0] iCode,
  input  logic              iCodeValid,
  output logic              oCodeReady,
  input  logic              iFlush,
  output logic              oFlushDone,
  output logic [WORD_W-1:0] oWord,
  output logic              oWordValid,
  input  logic              iWordReady,
  output logic [15:0]       oWordCount,
  output logic              oBusy
);

  // The accumulator holds at most WORD_W-1 leftover bits plus one new code.
  localparam int ACC_W  = WORD_W + CODE_W - 1;
  localparam int CNT_W  = $clog2(WORD_W);
  localparam int BITS_W = $clog2(ACC_W + 1);
  localparam int PAD_W  = CNT_W + 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] FIFO_FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic              flushDone;
  // Pending bits are kept right-aligned: bit bitCount-1 is the oldest one.
  logic [ACC_W-1:0]  accBits;
  logic [CNT_W-1:0]  bitCount;

  logic [WORD_W-1:0] fifoMem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W:0]   fifoCount;
  logic [15:0]       wordCount;

  logic              fifoFull;
  logic              fifoEmpty;
  logic              codeAccept;
  logic              popEn;
  logic              pushEn;
  logic [WORD_W-1:0] pushWord;
  logic [ACC_W-1:0]  nextAcc;
  logic [CNT_W-1:0]  nextCount;
  logic [ACC_W-1:0]  catBits;
  logic [ACC_W-1:0]  keepMask;
  logic [BITS_W-1:0] sumBits;
  logic [BITS_W-1:0] alignShift;
  logic [PAD_W-1:0]  padShift;

  assign fifoFull   = (fifoCount == FIFO_FULL_CNT);
  assign fifoEmpty  = (fifoCount == {(ADDR_W + 1){1'b0}});
  assign oCodeReady = (state == PACK) && !fifoFull;
  assign codeAccept = iCodeValid && oCodeReady;
  assign popEn      = !fifoEmpty && iWordReady;
  assign oWord      = fifoMem[rdPtr];
  assign oWordValid = !fifoEmpty;
  assign oWordCount = wordCount;
  assign oFlushDone = flushDone;
  assign oBusy      = (state != PACK) || (bitCount != {CNT_W{1'b0}}) || !fifoEmpty;

  // Append/extract datapath: decides the push word and the next accumulator.
  always_comb begin
    // New code goes below the existing bits; the top bits of the old
    // accumulator are always zero because bitCount never exceeds WORD_W-1.
    catBits    = {accBits[ACC_W-CODE_W-1:0], iCode};
    sumBits    = BITS_W'(bitCount) + BITS_W'(CODE_W);
    alignShift = sumBits - BITS_W'(WORD_W);
    padShift   = PAD_W'(WORD_W) - {1'b0, bitCount};
    nextAcc    = accBits;
    nextCount  = bitCount;
    keepMask   = {ACC_W{1'b1}};
    pushEn     = 1'b0;
    pushWord   = {WORD_W{1'b0}};
    if (codeAccept) begin
      if (sumBits >= BITS_W'(WORD_W)) begin
        pushEn    = 1'b1;
        pushWord  = WORD_W'(catBits >> alignShift);
        nextCount = CNT_W'(alignShift);
      end else begin
        nextCount = CNT_W'(sumBits);
      end
      // Drop the bits that just left in the pushed word.
      keepMask = (ACC_W'(1) << nextCount) - ACC_W'(1);
      nextAcc  = catBits & keepMask;
    end else if ((state == FLUSH) && (bitCount != {CNT_W{1'b0}}) && !fifoFull) begin
      // Left-align the remainder; the shift fills the tail with zeros.
      pushEn    = 1'b1;
      pushWord  = WORD_W'(accBits << padShift);
      nextAcc   = {ACC_W{1'b0}};
      nextCount = {CNT_W{1'b0}};
    end else begin
      nextAcc   = accBits;
      nextCount = bitCount;
    end
  end

  // Accumulator and bit-count registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      accBits  <= {ACC_W{1'b0}};
      bitCount <= {CNT_W{1'b0}};
    end else begin
      accBits  <= nextAcc;
      bitCount <= nextCount;
    end
  end

  // Flush sequencing FSM with registered completion pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= PACK;
      flushDone <= 1'b0;
    end else begin
      case (state)
        PACK: begin
          flushDone <= 1'b0;
          if (iFlush) begin
            state <= FLUSH;
          end else begin
            state <= PACK;
          end
        end
        FLUSH: begin
          // Completion needs both the remainder pushed and the FIFO drained.
          if ((bitCount == {CNT_W{1'b0}}) && fifoEmpty) begin
            state     <= DONE;
            flushDone <= 1'b1;
          end else begin
            state     <= FLUSH;
            flushDone <= 1'b0;
          end
        end
        DONE: begin
          state     <= PACK;
          flushDone <= 1'b0;
        end
        default: begin
          state     <= PACK;
          flushDone <= 1'b0;
        end
      endcase
    end
  end

  // Output word FIFO; the producer never pushes while full.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem[i] <= {WORD_W{1'b0}};
      end
      wrPtr     <= {ADDR_W{1'b0}};
      rdPtr     <= {ADDR_W{1'b0}};
      fifoCount <= {(ADDR_W + 1){1'b0}};
    end else begin
      if (pushEn) begin
        fifoMem[wrPtr] <= pushWord;
        wrPtr          <= wrPtr + ADDR_W'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + ADDR_W'(1);
      end
      case ({pushEn, popEn})
        2'b10:   fifoCount <= fifoCount + (ADDR_W + 1)'(1);
        2'b01:   fifoCount <= fifoCount - (ADDR_W + 1)'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Count of words handed to the consumer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wordCount <= 16'h0000;
    end else if (popEn) begin
      wordCount <= wordCount + 16'h0001;
    end else begin
      wordCount <= wordCount;
    end
  end

endmodule

// File: tb/tb_lzw_code_packer.sv
// Bench for lzw_code_packer: a fixed per-cycle table for the documented
// sequences, then hand-written and random sequences checked against a
// bit-queue reference model.
module tb_lzw_code_packer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [11:0] iCode = 12'h000;
  logic        iCodeValid = 1'b0;
  logic        iFlush = 1'b0;
  logic        iWordReady = 1'b0;
  logic        oCodeReady;
  logic        oFlushDone;
  logic [15:0] oWord;
  logic        oWordValid;
  logic [15:0] oWordCount;
  logic        oBusy;

  lzw_code_packer #(.CODE_W(12), .WORD_W(16), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .iCode(iCode), .iCodeValid(iCodeValid),
    .oCodeReady(oCodeReady), .iFlush(iFlush), .oFlushDone(oFlushDone),
    .oWord(oWord), .oWordValid(oWordValid), .iWordReady(iWordReady),
    .oWordCount(oWordCount), .oBusy(oBusy)
  );

  always #5 Clk = ~Clk;

  int nVec = 0;
  int nMis = 0;

  task automatic chkBit(input string nm, input logic act, input logic exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkWord(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %04h expected %04h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic failNow(input string nm);
    nVec++;
    nMis++;
    $display("FAIL %s: condition not met at %0t", nm, $time);
  endtask

  // Reference model: bits in stream order, words expected but not yet popped.
  bit          bq[$];
  logic [15:0] expq[$];
  logic [15:0] popCnt = 16'h0000;
  bit          flushing = 1'b0;
  int          flushAge = 0;

  task automatic modelAccept(input logic [11:0] c);
    logic [15:0] w;
    for (int i = 11; i >= 0; i--) bq.push_back(c[i]);
    while (bq.size() >= 16) begin
      w = 16'h0000;
      for (int i = 0; i < 16; i++) w = {w[14:0], bq.pop_front()};
      expq.push_back(w);
    end
  endtask

  task automatic modelPad();
    logic [15:0] w;
    if (bq.size() > 0) begin
      w = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        if (bq.size() > 0) w = {w[14:0], bq.pop_front()};
        else               w = {w[14:0], 1'b0};
      end
      expq.push_back(w);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, update the model.
  task automatic step(input logic cv, input logic [11:0] code, input logic fl,
                      input logic wr, output bit acc);
    logic [15:0] w;
    iCodeValid = cv; iCode = code; iFlush = fl; iWordReady = wr;
    @(negedge Clk);
    chkBit("codeReady", oCodeReady, !flushing && (expq.size() < 4));
    if (!flushing) chkBit("wordValid", oWordValid, expq.size() != 0);
    chkBit("busy", oBusy, flushing || (bq.size() != 0) || (expq.size() != 0));
    chkWord("wordCount", oWordCount, popCnt);
    if (oFlushDone && !flushing) failNow("spuriousFlushDone");
    if (oWordValid && wr) begin
      if (expq.size() == 0) failNow("unexpectedWord");
      else begin
        w = expq.pop_front();
        chkWord("word", oWord, w);
      end
      popCnt = popCnt + 16'd1;
    end
    acc = cv && oCodeReady;
    if (acc) modelAccept(code);
    if (fl && !flushing) begin
      modelPad();
      flushing = 1'b1;
      flushAge = 0;
    end else if (flushing) begin
      flushAge++;
      if (oFlushDone) flushing = 1'b0;
      else if (flushAge > 64) begin
        failNow("flushTimeout");
        flushing = 1'b0;
      end
    end
    @(posedge Clk); #1;
  endtask

  // Close out any flush in progress, then flush and drain completely.
  task automatic finishStream();
    bit a;
    for (int k = 0; k < 100 && flushing; k++) step(1'b0, 12'h000, 1'b0, 1'b1, a);
    step(1'b0, 12'h000, 1'b1, 1'b1, a);
    for (int k = 0; k < 100 && flushing; k++) step(1'b0, 12'h000, 1'b0, 1'b1, a);
    if (flushing) failNow("drainTimeout");
  endtask

  typedef struct {
    logic        cv;
    logic [11:0] code;
    logic        fl;
    logic        wr;
    logic        eReady;
    logic        eValid;
    logic [15:0] eWord;
    logic        eDone;
    logic        eBusy;
    logic [15:0] eCount;
  } vec_t;

  vec_t tbl [21];

  initial begin
    bit          a;
    logic        rCv;
    logic [11:0] rCode;
    logic [15:0] base;

    tbl[0]  = '{1'b1, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 12'hDEF, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 12'h123, 1'b0, 1'b1, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 12'h456, 1'b0, 1'b1, 1'b1, 1'b1, 16'hEF12, 1'b0, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3456, 1'b0, 1'b1, 16'd2};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd3};
    tbl[6]  = '{1'b1, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd3};
    tbl[7]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd3};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd3};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hABC0, 1'b0, 1'b1, 16'd3};
    tbl[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd4};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd4};
    tbl[12] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd4};
    tbl[13] = '{1'b1, 12'h123, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd4};
    tbl[14] = '{1'b1, 12'h456, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd4};
    tbl[15] = '{1'b1, 12'h78A, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 16'd4};
    tbl[16] = '{1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b1, 16'd5};
    tbl[17] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 16'hAFFF, 1'b0, 1'b1, 16'd6};
    tbl[18] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd7};
    tbl[19] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd7};
    tbl[20] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd7};

    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    chkBit("rstReady", oCodeReady, 1'b1);
    chkBit("rstValid", oWordValid, 1'b0);
    chkBit("rstDone", oFlushDone, 1'b0);
    chkBit("rstBusy", oBusy, 1'b0);
    chkWord("rstCount", oWordCount, 16'h0000);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Fixed sequences: four-code run, single code + flush, flush with residual.
    for (int i = 0; i < 21; i++) begin
      iCodeValid = tbl[i].cv; iCode = tbl[i].code;
      iFlush = tbl[i].fl; iWordReady = tbl[i].wr;
      @(negedge Clk);
      chkBit("tblReady", oCodeReady, tbl[i].eReady);
      chkBit("tblValid", oWordValid, tbl[i].eValid);
      if (tbl[i].eValid) chkWord("tblWord", oWord, tbl[i].eWord);
      chkBit("tblDone", oFlushDone, tbl[i].eDone);
      chkBit("tblBusy", oBusy, tbl[i].eBusy);
      chkWord("tblCount", oWordCount, tbl[i].eCount);
      @(posedge Clk); #1;
    end
    popCnt = 16'd7;

    // Backpressure: six codes fill the FIFO, the seventh must wait.
    for (int k = 1; k <= 6; k++) step(1'b1, 12'(k), 1'b0, 1'b0, a);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 12'h007, 1'b0, 1'b0, a);
      if (a) failNow("heldCodeTaken");
    end
    a = 1'b0;
    for (int k = 0; k < 10 && !a; k++) step(1'b1, 12'h007, 1'b0, 1'b1, a);
    if (!a) failNow("heldCodeNeverTaken");
    finishStream();

    // Continuous codes with the consumer always ready: 64 codes -> 48 words.
    base = popCnt;
    for (int k = 0; k < 64; k++) step(1'b1, 12'($urandom), 1'b0, 1'b1, a);
    for (int k = 0; k < 4; k++) step(1'b0, 12'h000, 1'b0, 1'b1, a);
    chkWord("words64", oWordCount, base + 16'd48);

    // Random traffic with occasional flushes; codes held until accepted.
    rCv = 1'b0; rCode = 12'h000;
    for (int i = 0; i < 800; i++) begin
      if (!rCv) begin
        rCv   = ($urandom_range(0, 9) < 7);
        rCode = 12'($urandom);
      end
      step(rCv, rCode, ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 6), a);
      if (a) rCv = 1'b0;
    end
    finishStream();

    // Asynchronous reset with three words queued and bits pending.
    for (int k = 0; k < 5; k++) step(1'b1, 12'($urandom), 1'b0, 1'b0, a);
    #2 Reset_n = 1'b0;
    #1;
    chkBit("asyncRstValid", oWordValid, 1'b0);
    chkWord("asyncRstCount", oWordCount, 16'h0000);
    chkBit("asyncRstBusy", oBusy, 1'b0);
    chkBit("asyncRstReady", oCodeReady, 1'b1);
    bq.delete(); expq.delete(); popCnt = 16'h0000; flushing = 1'b0;
    iCodeValid = 1'b0; iFlush = 1'b0;
    @(negedge Clk); #1 Reset_n = 1'b1;
    @(posedge Clk); #1;
    step(1'b1, 12'hABC, 1'b0, 1'b1, a);
    step(1'b1, 12'hDEF, 1'b0, 1'b1, a);
    step(1'b0, 12'h000, 1'b0, 1'b1, a);
    chkWord("postRstCount", oWordCount, 16'd1);
    finishStream();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
